uart_rx_hsk: RTL and testbench

UART_RX_HSK -- requirements
Module: uart_rx_hsk

---
 rtl/uart_rx_hsk_pkg.sv | 17 +
 rtl/bit_sync.sv | 28 ++
 rtl/uart_rx_hsk.sv | 159 +++++++++++++++
 tb/tb_uart_rx_hsk.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_hsk_pkg.sv
// Shared encodings for the UART receiver with four-phase output handshake.
// Receive and handshake state constants plus the default bit period.
package uart_rx_hsk_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_STOP      = 3'd3;
    localparam logic [2:0] RX_WAIT_IDLE = 3'd4;

    localparam logic [1:0] HS_IDLE    = 2'd0;
    localparam logic [1:0] HS_REQ     = 2'd1;
    localparam logic [1:0] HS_RELEASE = 2'd2;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is a parameter so idle-high lines come out of reset idle.
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_hsk.sv
// 8N1 UART receiver delivering bytes over a four-phase req/ack handshake.
// A frame finishing while the handshake is still busy is dropped as overrun.
module uart_rx_hsk
    import uart_rx_hsk_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_rx,
    input  logic       in_rx_enable,
    output logic [7:0] out_data,
    output logic       out_data_hsk_req,
    input  logic       in_data_hsk_ack,
    output logic       out_frame_err,
    output logic       out_overrun
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    logic        rx_s;
    logic [2:0]  rx_q, rx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        frame_ok;
    logic        frame_bad;

    logic [1:0]  hs_q;
    logic [7:0]  data_q;
    logic        err_q;
    logic        ovr_q;

    bit_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (in_clk),
        .rst_i (in_rst),
        .d_i   (in_rx),
        .q_o   (rx_s)
    );

    // Receive FSM next state: start qualify, mid-bit sampling, stop check
    always_comb begin
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (rx_q)
            RX_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (!rx_s && in_rx_enable) begin
                    rx_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    rx_d  = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        rx_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        frame_ok = 1'b1;
                        rx_d     = RX_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        rx_d      = RX_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s) begin
                    rx_d = RX_IDLE;
                end
            end
            default: begin
                rx_d  = RX_IDLE;
                cnt_d = 16'd0;
                idx_d = 3'd0;
            end
        endcase
    end

    // Receive FSM state registers
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rx_q    <= RX_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Handshake FSM; release-to-idle in the same cycle still counts busy
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            hs_q   <= HS_IDLE;
            data_q <= 8'h00;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            err_q <= frame_bad;
            ovr_q <= frame_ok && (hs_q != HS_IDLE);
            case (hs_q)
                HS_IDLE: begin
                    if (frame_ok) begin
                        data_q <= shift_q;
                        hs_q   <= HS_REQ;
                    end
                end
                HS_REQ: begin
                    if (in_data_hsk_ack) begin
                        hs_q <= HS_RELEASE;
                    end
                end
                HS_RELEASE: begin
                    if (!in_data_hsk_ack) begin
                        hs_q <= HS_IDLE;
                    end
                end
                default: hs_q <= HS_IDLE;
            endcase
        end
    end

    assign out_data         = data_q;
    assign out_data_hsk_req = (hs_q == HS_REQ);
    assign out_frame_err    = err_q;
    assign out_overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_hsk.sv
// Scoreboard bench for uart_rx_hsk at 8 clocks per bit.
// Sender pushes expected bytes; a negedge monitor pops on each req rise.
module tb_uart_rx_hsk;
    import uart_rx_hsk_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       en = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       req;
    logic       ferr;
    logic       ovr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_start = 0;
    int req_rise = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    bit auto_ack = 1'b1;
    bit chk_lat = 1'b0;
    logic [7:0] q[$];

    uart_rx_hsk #(
        .CLKS_PER_BIT (8)
    ) dut (
        .in_clk           (clk),
        .in_rst           (rst),
        .in_rx            (rx),
        .in_rx_enable     (en),
        .out_data         (data),
        .out_data_hsk_req (req),
        .in_data_hsk_ack  (ack),
        .out_frame_err    (ferr),
        .out_overrun      (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        rx = 1'b0;
        last_start = cyc;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (8) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (8) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic drain(input string n);
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk(n, q.size(), 0);
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations on req rise, counts pulses
    initial begin
        logic       req_prev;
        logic       err_prev;
        logic [7:0] held;
        logic [7:0] exp;
        req_prev = 1'b0;
        err_prev = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req && !req_prev) begin
                    req_rise++;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: got %0h expected none",
                                 data);
                    end else begin
                        exp = q.pop_front();
                        chk("rx_byte", data, exp);
                    end
                    if (chk_lat) begin
                        chk("req_latency", cyc - last_start, 79);
                        chk_lat = 1'b0;
                    end
                    held = data;
                end else if (req && req_prev) begin
                    if (data !== held) chk("data_stable", data, held);
                end
                if (ferr) err_cnt++;
                if (ferr && err_prev) chk("err_pulse_width", 2, 1);
                if (ovr) ovr_cnt++;
            end
            req_prev = req;
            err_prev = ferr;
        end
    end

    // Consumer: echoes req with ack after 3 cycles
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && req && !ack && !rst) begin
                repeat (3) @(posedge clk);
                #1 ack = 1'b1;
                @(negedge clk);
                chk("req_hold", req, 1);
                @(negedge clk);
                chk("req_fall", req, 0);
                @(posedge clk);
                #1 ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_req", req, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Basic byte with timing checks
        q.push_back(8'hA5);
        chk_lat = 1'b1;
        send(8'hA5, 1'b1);
        drain("drain_a5");
        chk("a5_count", req_rise, 1);

        // Bad stop bit, then recovery
        send(8'h3C, 1'b0);
        repeat (4) @(posedge clk);
        chk("ferr_count", err_cnt, 1);
        chk("ferr_no_req", req_rise, 1);
        q.push_back(8'h01);
        send(8'h01, 1'b1);
        drain("drain_01");

        // Short glitch on idle line
        @(posedge clk); #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_state", dut.rx_q, RX_IDLE);
        chk("glitch_req", req_rise, 2);
        chk("glitch_ferr", err_cnt, 1);
        chk("glitch_ovr", ovr_cnt, 0);

        // Back-to-back with ack held low
        auto_ack = 1'b0;
        q.push_back(8'h11);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ovr_count", ovr_cnt, 1);
        chk("ovr_data", data, 8'h11);
        chk("ovr_req", req, 1);
        @(posedge clk); #1 ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ovr_req_fall", req, 0);
        @(posedge clk); #1 ack = 1'b0;
        repeat (4) @(posedge clk);
        auto_ack = 1'b1;

        // Enable low ignores start; rising mid-frame on a high bit
        en = 1'b0;
        fork
            send(8'hF0, 1'b1);
            begin
                repeat (52) @(posedge clk);
                #1 en = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        chk("en_ignored", req_rise, 3);
        q.push_back(8'h96);
        send(8'h96, 1'b1);
        drain("drain_96");

        // Reset in the middle of a frame
        fork
            send(8'hFF, 1'b1);
            begin
                repeat (30) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("midrst_data", data, 8'h00);
                chk("midrst_req", req, 0);
                chk("midrst_ferr", ferr, 0);
                chk("midrst_ovr", ovr, 0);
                @(posedge clk); #1 rst = 1'b0;
            end
        join
        repeat (10) @(posedge clk);
        q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        drain("drain_5a");

        chk("final_req_count", req_rise, 5);
        chk("final_ferr", err_cnt, 1);
        chk("final_ovr", ovr_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
